// File: rtl/dct_pkg.sv
// Shared widths and helpers for the 1-D DCT datapath.
package dct_pkg;

  localparam int ACC_W       = 32;
  localparam int PIX_W_DEF   = 9;
  localparam int COEF_W_DEF  = 12;
  localparam int N_TERMS_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/recurse.sv
// 32-bit recursive-doubling (Kogge-Stone) adder; carry-in is tied to zero.
module recurse
  import dct_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LVLS = clog2(W);

  logic [W-1:0] g_s [0:LVLS];
  logic [W-1:0] p_s [0:LVLS-1];

  assign g_s[0] = a & b;
  assign p_s[0] = a ^ b;

  // Each level doubles the span covered by the group generate/propagate terms.
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i-(1<<l)]);
        if (l < LVLS - 1) begin : g_prop
          assign p_s[l+1][i] = p_s[l][i] & p_s[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign g_s[l+1][i] = g_s[l][i];
        if (l < LVLS - 1) begin : g_prop
          assign p_s[l+1][i] = p_s[l][i];
        end
      end
    end
  end

  assign sum  = p_s[0] ^ {g_s[LVLS][W-2:0], 1'b0};
  assign cout = g_s[LVLS][W-1];

endmodule

// File: rtl/dct_mac8.sv
// Two-stage multiply-accumulate for the 1-D DCT: signed product, then an
// N_TERMS-term running sum released on a valid/ready output.
module dct_mac8
  import dct_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int COEF_W  = COEF_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PIX_W-1:0]     in_pix,
  input  logic signed [COEF_W-1:0]    in_coef,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_W-1:0]     out_data,
  output logic [clog2(N_TERMS)-1:0]   out_idx
);

  localparam int CNT_W  = clog2(N_TERMS);
  localparam int PROD_W = PIX_W + COEF_W;

  if ((N_TERMS < 2) || ((1 << CNT_W) != N_TERMS) || (PROD_W + CNT_W > ACC_W)) begin : g_chk
    $fatal(1, "dct_mac8: N_TERMS must be a power of two >= 2 and the sum must fit 32 bits");
  end

  logic                     stall_s;
  logic                     accept_s;
  logic signed [PROD_W-1:0] mul_s;
  logic [ACC_W-1:0]         prod_ext_s;
  logic [ACC_W-1:0]         acc_op_s;
  logic [ACC_W-1:0]         sum_s;
  logic                     carry_unused_s;

  logic [ACC_W-1:0]         prod_r;
  logic                     prod_v_r;
  logic                     first_r;
  logic                     last_r;
  logic [CNT_W-1:0]         term_cnt_r;
  logic [ACC_W-1:0]         acc_r;

  assign stall_s    = out_valid & ~out_ready;
  assign in_ready   = ~stall_s;
  assign accept_s   = in_valid & ~stall_s;
  assign mul_s      = in_pix * in_coef;
  assign prod_ext_s = {{(ACC_W-PROD_W){mul_s[PROD_W-1]}}, mul_s};
  assign acc_op_s   = first_r ? {ACC_W{1'b0}} : acc_r;

  recurse #(.W(ACC_W)) u_add (
    .a    (acc_op_s),
    .b    (prod_r),
    .sum  (sum_s),
    .cout (carry_unused_s)
  );

  // Product stage: register the sign-extended product with block position tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= {ACC_W{1'b0}};
      prod_v_r   <= 1'b0;
      first_r    <= 1'b0;
      last_r     <= 1'b0;
      term_cnt_r <= {CNT_W{1'b0}};
    end else if (!stall_s) begin
      prod_v_r <= accept_s;
      if (accept_s) begin
        prod_r     <= prod_ext_s;
        first_r    <= (term_cnt_r == {CNT_W{1'b0}});
        last_r     <= (term_cnt_r == CNT_W'(N_TERMS - 1));
        term_cnt_r <= term_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Accumulate stage: first term of a block restarts the sum from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (prod_v_r && !stall_s) begin
      acc_r <= sum_s;
    end
  end

  // Output register: load on block completion, clear on release, index per release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {ACC_W{1'b0}};
      out_idx   <= {CNT_W{1'b0}};
    end else if (!stall_s) begin
      if (prod_v_r && last_r) begin
        out_data  <= sum_s;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        out_idx <= out_idx + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_dct_mac8.sv
// Scoreboard bench for dct_mac8: a software dot product queues each expected
// coefficient at the accept of its last term; results are popped on release.
module tb_dct_mac8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [8:0]  in_pix;
  logic signed [11:0] in_coef;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [2:0]         out_idx;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          errors  = 0;
  int          m_sum   = 0;
  int          m_cnt   = 0;
  logic [2:0]  m_idx   = 3'd0;
  int          cyc     = 0;
  logic        s_acc, s_rel, s_ir, s_ov;
  logic [31:0] s_data;
  logic [2:0]  s_idx;

  always #5 clk = ~clk;

  dct_mac8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  // Drive one cycle of inputs, sample the handshakes and update the reference model.
  task automatic step(input logic v, input logic signed [8:0] p, input logic signed [11:0] c, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_pix    = p;
    in_coef   = c;
    out_ready = r;
    #1;
    s_acc  = in_valid & in_ready;
    s_rel  = out_valid & out_ready;
    s_ir   = in_ready;
    s_ov   = out_valid;
    s_data = out_data;
    s_idx  = out_idx;
    cyc++;
    if (s_acc) begin
      m_sum = m_sum + int'(p) * int'(c);
      m_cnt++;
      if (m_cnt == 8) begin
        sb.push_back('{data: m_sum, idx: m_idx});
        m_idx = m_idx + 3'd1;
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    m_idx = 3'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pix = 9'sd0;
    in_coef = 12'sd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'sd0 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_values got in_ready=%b out_valid=%b out_data=%0d out_idx=%0d required 1 0 0 0",
               in_ready, out_valid, out_data, out_idx);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int t = 0;
    int last_acc = -100;
    int rel_at = -1;
    for (int k = 0; k < 40 && (t < 8 || sb.size() > 0); k++) begin
      step(t < 8, 9'(t + 1), 12'sd1, 1'b1);
      if (s_acc) begin
        t++;
        if (t == 8) last_acc = cyc;
      end
      if (s_rel) begin
        rel_at = cyc;
        vectors++;
        if (s_data !== 32'd36 || s_idx !== 3'd0) begin
          errors++;
          $display("FAIL basic_sum got %0d idx %0d required 36 idx 0", $signed(s_data), s_idx);
        end
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL basic_sb got result %0d required none", $signed(s_data));
        end else begin
          e = sb.pop_front();
          if (s_data !== e.data || s_idx !== e.idx) begin
            errors++;
            $display("FAIL basic_sb got %0d/%0d required %0d/%0d", $signed(s_data), s_idx, $signed(e.data), e.idx);
          end
        end
      end
    end
    vectors++;
    if (rel_at - last_acc != 2) begin
      errors++;
      $display("FAIL basic_latency got %0d cycles required 2", rel_at - last_acc);
    end
  endtask

  task automatic test_sign();
    int t = 0;
    logic got = 1'b0;
    for (int k = 0; k < 40 && (t < 8 || sb.size() > 0); k++) begin
      step(t < 8, (t % 2 == 0) ? 9'sd255 : 9'h100, 12'h800, 1'b1);
      if (s_acc) t++;
      if (s_rel) begin
        got = 1'b1;
        vectors++;
        if (s_data !== 32'd8192 || s_idx !== 3'd1) begin
          errors++;
          $display("FAIL sign_sum got %0d idx %0d required 8192 idx 1", $signed(s_data), s_idx);
        end
        if (sb.size() > 0) e = sb.pop_front();
      end
    end
    vectors++;
    if (!got || sb.size() != 0) begin
      errors++;
      $display("FAIL sign_timeout got released=%b pending=%0d required 1 0", got, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int nrel = 0;
    int prev = 0;
    int stim_steps = 0;
    logic signed [8:0]  p;
    logic signed [11:0] c;
    do_reset();
    p = 9'sd1;
    c = 12'sd1;
    for (int k = 0; k < 100 && (t < 32 || sb.size() > 0); k++) begin
      if (t < 32) stim_steps++;
      step(t < 32, p, c, 1'b1);
      if (s_acc) begin
        t++;
        if (t >= 8) begin
          p = 9'($urandom);
          c = 12'($urandom);
        end
      end
      if (s_rel) begin
        vectors++;
        if (nrel > 0 && cyc - prev != 8) begin
          errors++;
          $display("FAIL b2b_interval got %0d required 8", cyc - prev);
        end
        if (nrel == 0 && s_data !== 32'd8) begin
          errors++;
          $display("FAIL b2b_first got %0d required 8", $signed(s_data));
        end
        prev = cyc;
        nrel++;
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb got result %0d required none", $signed(s_data));
        end else begin
          e = sb.pop_front();
          if (s_data !== e.data || s_idx !== e.idx) begin
            errors++;
            $display("FAIL b2b_sb got %0d/%0d required %0d/%0d", $signed(s_data), s_idx, $signed(e.data), e.idx);
          end
        end
      end
    end
    vectors++;
    if (nrel != 4 || stim_steps != 32) begin
      errors++;
      $display("FAIL b2b_count got results=%0d steps=%0d required 4 32", nrel, stim_steps);
    end
  endtask

  task automatic test_stall();
    logic signed [8:0]  pa [16];
    logic signed [11:0] ca [16];
    int t = 0;
    int stalls = 0;
    logic [31:0] held_d;
    logic [2:0]  held_i;
    for (int i = 0; i < 16; i++) begin
      pa[i] = 9'($urandom);
      ca[i] = 12'($urandom);
    end
    for (int k = 0; k < 80 && (t < 16 || sb.size() > 0); k++) begin
      step(t < 16, pa[t % 16], ca[t % 16], (k >= 8 && k < 18) ? 1'b0 : 1'b1);
      if (s_acc) t++;
      if (s_ov && !out_ready) begin
        vectors++;
        if (s_ir !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready got %b required 0", s_ir);
        end
        if (stalls == 0) begin
          held_d = s_data;
          held_i = s_idx;
        end else if (s_data !== held_d || s_idx !== held_i) begin
          errors++;
          $display("FAIL stall_hold got %0d/%0d required %0d/%0d", $signed(s_data), s_idx, $signed(held_d), held_i);
        end
        stalls++;
      end
      if (s_rel) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stall_sb got result %0d required none", $signed(s_data));
        end else begin
          e = sb.pop_front();
          if (s_data !== e.data || s_idx !== e.idx) begin
            errors++;
            $display("FAIL stall_sb got %0d/%0d required %0d/%0d", $signed(s_data), s_idx, $signed(e.data), e.idx);
          end
        end
      end
    end
    vectors++;
    if (stalls != 9 || t != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count got stalls=%0d terms=%0d pending=%0d required 9 16 0", stalls, t, sb.size());
    end
  endtask

  task automatic test_random();
    int t = 0;
    logic signed [8:0]  p;
    logic signed [11:0] c;
    p = 9'($urandom);
    c = 12'($urandom);
    for (int k = 0; k < 60000 && (t < 8000 || sb.size() > 0); k++) begin
      step((t < 8000) && ($urandom_range(0, 1) == 1), p, c, $urandom_range(0, 1) == 1);
      if (s_acc) begin
        t++;
        p = 9'($urandom);
        c = 12'($urandom);
      end
      if (s_rel) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL random_sb got result %0d required none", $signed(s_data));
        end else begin
          e = sb.pop_front();
          if (s_data !== e.data || s_idx !== e.idx) begin
            errors++;
            $display("FAIL random_sb got %0d/%0d required %0d/%0d", $signed(s_data), s_idx, $signed(e.data), e.idx);
          end
        end
      end
    end
    vectors++;
    if (t != 8000 || sb.size() != 0) begin
      errors++;
      $display("FAIL random_timeout got terms=%0d pending=%0d required 8000 0", t, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    for (int k = 0; k < 20 && t < 5; k++) begin
      step(1'b1, 9'sd100, 12'sd7, 1'b1);
      if (s_acc) t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'sd0 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL midreset_values got in_ready=%b out_valid=%b out_data=%0d out_idx=%0d required 1 0 0 0",
               in_ready, out_valid, out_data, out_idx);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    m_idx = 3'd0;
    sb.delete();
    t = 0;
    for (int k = 0; k < 40 && (t < 8 || sb.size() > 0); k++) begin
      step(t < 8, 9'(t + 2), 12'sd3, 1'b1);
      if (s_acc) t++;
      if (s_rel) begin
        vectors++;
        if (s_data !== 32'd132 || s_idx !== 3'd0) begin
          errors++;
          $display("FAIL midreset_sum got %0d idx %0d required 132 idx 0", $signed(s_data), s_idx);
        end
        if (sb.size() > 0) e = sb.pop_front();
      end
    end
    vectors++;
    if (t != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_timeout got terms=%0d pending=%0d required 8 0", t, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
